dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the 8-bit data memory. It accepts load/store requests from two requesters (port 0: core load/store stage, port 1: debug/loader port) and grants the memory to one of them at a time, round-robin or fixed priority. It drives the memory's `address`/`write_data`/`mem_write`/`mem_read` inputs and returns read data with a one-cycle `ack` pulse. The memory it drives performs the access on the rising clock edge and registers `data_out` for loads.

---
 rtl/dmem_arbiter.sv | 90 +++++++++
 tb/tb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 8-bit data memory.
// Each transaction is three cycles: a grant edge, one strobe cycle, then a one-cycle ack.
module dmem_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              grant_id,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t r_state;
  logic   r_last;
  logic   w_any;
  logic   w_pick;
  logic   w_we;

  // Port 1 wins if it is the only requester, or on a tie when round-robin
  // and port 0 was granted last.
  assign w_any  = req0 | req1;
  assign w_pick = req1 & (~req0 | ((FIXED_PRIORITY == 0) & ~r_last));
  assign w_we   = w_pick ? we1 : we0;

  assign rdata  = (ack0 | ack1) ? mem_data_out : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_last         <= 1'b1;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      grant_id       <= 1'b0;
      busy           <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state        <= ACCESS;
            busy           <= 1'b1;
            grant_id       <= w_pick;
            r_last         <= w_pick;
            mem_address    <= w_pick ? addr1 : addr0;
            mem_write_data <= w_pick ? wdata1 : wdata0;
            mem_write      <= w_we;
            mem_read       <= ~w_we;
          end
        end
        ACCESS: begin
          r_state   <= DONE;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          ack0      <= ~grant_id;
          ack1      <= grant_id;
        end
        DONE: begin
          r_state <= IDLE;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: a round-robin instance (A) and a fixed-priority instance (B),
// each driving its own behavioural memory preloaded with loc+1.
module tb_dmem_arbiter;

  typedef struct {
    int         port;
    bit         st;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // ---------------- instance A: round-robin ----------------
  logic       a_req0 = 0, a_req1 = 0, a_we0 = 0, a_we1 = 0;
  logic [7:0] a_addr0 = 0, a_addr1 = 0, a_wd0 = 0, a_wd1 = 0;
  logic       a_ack0, a_ack1, a_gid, a_busy, a_mw, a_mr;
  logic [7:0] a_rdata, a_maddr, a_mwd;
  logic [7:0] a_dout = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIORITY(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
    .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wd0), .wdata1(a_wd1),
    .ack0(a_ack0), .ack1(a_ack1), .rdata(a_rdata), .grant_id(a_gid), .busy(a_busy),
    .mem_address(a_maddr), .mem_write_data(a_mwd), .mem_write(a_mw), .mem_read(a_mr),
    .mem_data_out(a_dout)
  );

  logic [7:0]   a_mem [256];
  logic [255:0] a_wv = '0;
  always @(posedge clk) begin
    if (a_mw) begin
      a_mem[a_maddr] <= a_mwd;
      a_wv[a_maddr]  <= 1'b1;
    end
    if (a_mr) a_dout <= a_wv[a_maddr] ? a_mem[a_maddr] : a_maddr + 8'd1;
  end

  // ---------------- instance B: fixed priority ----------------
  logic       b_req0 = 0, b_req1 = 0;
  logic [7:0] b_addr0 = 8'h05, b_addr1 = 8'h07;
  logic       b_ack0, b_ack1, b_gid, b_busy, b_mw, b_mr;
  logic [7:0] b_rdata, b_maddr, b_mwd;
  logic [7:0] b_dout = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIORITY(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .req1(b_req1), .we0(1'b0), .we1(1'b0),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(8'h00), .wdata1(8'h00),
    .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .grant_id(b_gid), .busy(b_busy),
    .mem_address(b_maddr), .mem_write_data(b_mwd), .mem_write(b_mw), .mem_read(b_mr),
    .mem_data_out(b_dout)
  );

  // B only issues loads, so its memory never changes from loc+1.
  always @(posedge clk) if (b_mr) b_dout <= b_maddr + 8'd1;

  // ---------------- scoreboards / monitors ----------------
  exp_t qa[$];
  exp_t qb[$];
  bit   gap_a = 0, gap_b = 0;
  int   last_a = -1, last_b = -1;
  int   wr_a = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("a_strobe_excl", {a_mw, a_mr} == 2'b11, 0);
      chk("a_ack_excl", a_ack0 & a_ack1, 0);
    end
    if (a_mw) wr_a = wr_a + 1;
    if (!gap_a) last_a = -1;
    if (a_ack0 | a_ack1) begin
      if (qa.size() == 0) chk("a_unexpected_ack", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_ack_port", a_ack1, e.port);
        chk("a_grant_id", a_gid, e.port);
        if (!e.st) chk("a_rdata", a_rdata, e.d);
        if (gap_a && last_a >= 0) chk("a_ack_gap", cyc - last_a, 3);
        last_a = cyc;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) chk("b_ack_excl", b_ack0 & b_ack1, 0);
    if (!gap_b) last_b = -1;
    if (b_ack0 | b_ack1) begin
      if (qb.size() == 0) chk("b_unexpected_ack", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_ack_port", b_ack1, e.port);
        chk("b_grant_id", b_gid, e.port);
        chk("b_rdata", b_rdata, e.d);
        if (gap_b && last_b >= 0) chk("b_ack_gap", cyc - last_b, 3);
        last_b = cyc;
      end
    end
  end

  // Holds req high across n back-to-back transactions, dropping it at the last ack.
  task automatic drive_a(input int p, input bit we, input logic [7:0] a, input logic [7:0] wd,
                         input int n);
    int k;
    if (p == 0) begin a_we0 = we; a_addr0 = a; a_wd0 = wd; a_req0 = 1; end
    else        begin a_we1 = we; a_addr1 = a; a_wd1 = wd; a_req1 = 1; end
    for (int t = 0; t < n; t++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(p == 0 ? a_ack0 : a_ack1) && k < 40);
      if (k >= 40) begin
        chk("a_ack_timeout", 0, 1);
        break;
      end
    end
    if (p == 0) a_req0 = 0; else a_req1 = 0;
  endtask

  task automatic drive_b(input int p, input int n);
    int k;
    if (p == 0) b_req0 = 1; else b_req1 = 1;
    for (int t = 0; t < n; t++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(p == 0 ? b_ack0 : b_ack1) && k < 60);
      if (k >= 60) begin
        chk("b_ack_timeout", 0, 1);
        break;
      end
    end
    if (p == 0) b_req0 = 0; else b_req1 = 0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_ack", {a_ack0, a_ack1, b_ack0, b_ack1}, 0);
    chk("rst_strobes", {a_mw, a_mr, b_mw, b_mr}, 0);
    chk("rst_addr", a_maddr, 0);
    chk("rst_gid", {a_gid, b_gid}, 0);
    rst_n = 1;
    @(negedge clk);

    // single load on port 0 with explicit cycle timing
    qa.push_back('{port: 0, st: 0, d: 8'h11});
    a_req0 = 1; a_we0 = 0; a_addr0 = 8'h10;
    @(negedge clk);
    chk("t1_mem_read", a_mr, 1);
    chk("t1_mem_write", a_mw, 0);
    chk("t1_addr", a_maddr, 8'h10);
    chk("t1_busy", a_busy, 1);
    chk("t1_no_early_ack", a_ack0, 0);
    @(negedge clk);
    chk("t1_ack0", a_ack0, 1);
    chk("t1_ack1", a_ack1, 0);
    chk("t1_strobe_clear", a_mr, 0);
    a_req0 = 0;
    @(negedge clk);
    chk("t1_ack_drop", a_ack0, 0);
    chk("t1_busy_drop", a_busy, 0);

    // store then load on port 1
    wr_a = 0;
    qa.push_back('{port: 1, st: 1, d: 8'h00});
    drive_a(1, 1, 8'h20, 8'hA5, 1);
    chk("t2_write_cycles", wr_a, 1);
    qa.push_back('{port: 1, st: 0, d: 8'hA5});
    drive_a(1, 0, 8'h20, 8'h00, 1);
    @(negedge clk);

    // simultaneous round-robin: pointer is at port 1, so port 0 goes first
    for (int i = 0; i < 4; i++) begin
      qa.push_back('{port: 0, st: 0, d: 8'h02});
      qa.push_back('{port: 1, st: 0, d: 8'h03});
    end
    gap_a = 1;
    fork
      drive_a(0, 0, 8'h01, 8'h00, 4);
      drive_a(1, 0, 8'h02, 8'h00, 4);
    join
    gap_a = 0;
    @(negedge clk);

    // reset during ACCESS of a store must suppress the write
    a_req0 = 1; a_we0 = 1; a_addr0 = 8'h30; a_wd0 = 8'hFF;
    @(posedge clk);
    #1;
    chk("t5_in_access", a_mw, 1);
    rst_n = 0;
    #1;
    chk("t5_mw_killed", a_mw, 0);
    chk("t5_mr", a_mr, 0);
    chk("t5_busy", a_busy, 0);
    chk("t5_addr", a_maddr, 0);
    chk("t5_wdata", a_mwd, 0);
    chk("t5_acks", {a_ack0, a_ack1, a_rdata}, 0);
    a_req0 = 0; a_we0 = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    qa.push_back('{port: 0, st: 0, d: 8'h31});
    drive_a(0, 0, 8'h30, 8'h00, 1);

    // idle hold: last grant was port 0
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_idle", {a_busy, a_mw, a_mr, a_ack0, a_ack1, a_gid}, 0);
    end

    // fixed priority: port 0 takes all four, port 1 follows at the next IDLE
    for (int i = 0; i < 4; i++) qb.push_back('{port: 0, st: 0, d: 8'h06});
    qb.push_back('{port: 1, st: 0, d: 8'h08});
    gap_b = 1;
    fork
      drive_b(0, 4);
      drive_b(1, 1);
    join
    gap_b = 0;
    repeat (3) @(negedge clk);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
